// File: rtl/seg_share_ctrl.sv
// Round-robin arbiter sharing one 4-digit seven-segment path between N_REQ requesters.
// A granted 16-bit value is latched and held on screen for HOLD_TICKS scan ticks.
module seg_share_ctrl #(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned HOLD_TICKS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  data,
  output logic [N_REQ-1:0]     gnt,
  output logic [1:0]           owner,
  output logic                 busy,
  output logic [3:0]           d,
  output logic [3:0]           a
);

  localparam int unsigned CW = $clog2(HOLD_TICKS + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pend_eff;
  logic [3:0]      pend4;
  logic [3:0]      pick4;
  logic [2:0]      cand;
  logic [1:0]      pick_idx;
  logic            pick_vld;
  logic [1:0]      last;
  logic [CW-1:0]   hold_cnt;
  logic [15:0]     shown;
  logic [1:0]      dig;
  logic [63:0]     data64;

  assign data64 = 64'(data);

  // Requests in the current cycle are eligible immediately; search starts after last owner.
  always_comb begin
    pend_eff = pending | req;
    pend4    = 4'(pend_eff);
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = {1'b0, last} + 3'(off);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (!pick_vld && pend4[cand[1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[1:0];
      end
    end
    pick4 = pick_vld ? (4'b0001 << pick_idx) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= '0;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      shown    <= '0;
      dig      <= '0;
      d        <= '0;
      a        <= 4'b1110;
      hold_cnt <= '0;
      last     <= 2'(N_REQ - 1);
    end else begin
      // A request coinciding with its own grant pulse is dropped.
      pending <= pend_eff & ~gnt;
      gnt     <= '0;
      if (tick) dig <= dig + 2'd1;
      d <= shown[{dig, 2'b00} +: 4];
      a <= ~(4'b0001 << dig);
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt      <= pick4[N_REQ-1:0];
            owner    <= pick_idx;
            last     <= pick_idx;
            shown    <= data64[{pick_idx, 4'b0000} +: 16];
            hold_cnt <= CW'(HOLD_TICKS);
            busy     <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_cnt == CW'(1)) begin
              hold_cnt <= '0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              hold_cnt <= hold_cnt - CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
